riscv_data_bus: RTL and testbench
=================================

# riscv_data_bus

Data-side memory and I/O subsystem that sits directly downstream of the multicycle RISC-V processor's data port. Consumes `dAddress`, `dWriteData`, `MemRead` and `MemWrite`, and returns `dReadData` one cycle after a read is sampled. This matches the processor's MEM→WB sequencing. Decodes each access into a synchronous data RAM or a small memory-mapped I/O register file: LEDs, switches, buttons, a millisecond timer and a sticky status register.

## Interface
Parameters:
- `MEM_WORDS`, 1024: data RAM depth in 32-bit words (power of two).
- `DATA_BASE`, 32'h0000_2000: byte address of RAM word 0.
- `IO_BASE`, 32'h0000_7F00: byte address of the I/O register block.
- `CLK_HZ`, 100_000_000: clock frequency.
- `TICK_HZ`, 1000: timer increment rate.

Ports:
- `clk` in 1: single system clock, all state on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `dAddress` in 32: byte address from the processor.
- `dWriteData` in 32: store data.
- `MemRead` in 1: read request, sampled each rising edge.
- `MemWrite` in 1: write request, sampled each rising edge.
- `dReadData` out 32: registered read data.
- `sw` in 16: board switches, asynchronous.
- `btn` in 4: board buttons, asynchronous.
- `led` out 16: LED register.

## Operation
- **Word accesses only.** If `dAddress[1:0] != 0`, the access is dropped: no write, `dReadData` holds its value, and `status[0]` (misaligned) sets sticky.
- **Decode:**
  - RAM when `DATA_BASE <= dAddress < DATA_BASE + 4*MEM_WORDS`, index `(dAddress-DATA_BASE)>>2`.
  - I/O when `IO_BASE <= dAddress < IO_BASE+0x20`.
  - Everything else is unmapped: reads return 0 and writes are ignored. This is not an error.
- **I/O offsets:**
  - 0x00 LED: R/W, low 16 bits; upper bits read 0.
  - 0x04 switches: R, synchronized `sw`, zero-extended.
  - 0x08 buttons: R, synchronized `btn`, zero-extended.
  - 0x0C timer: R; any write clears it to 0.
  - 0x10 status: R, write-1-to-clear on bits [1:0].
  - Other offsets in the block read 0, and writes are ignored.
  - Writes to read-only registers are ignored.
- **Simultaneous MemRead & MemWrite:** the write is performed, the read is dropped (`dReadData` holds), and `status[1]` (collision) sets sticky.
- **Status races:** if a sticky set and a W1C clear hit the same bit on the same edge, the set wins.
- **Read data:** `dReadData` updates only on an edge where a valid read is sampled. Otherwise it holds its last value.
- **Synchronizers:** `sw` and `btn` each pass through a two-flop synchronizer. Register reads return the second-stage value.
- **Timer:**
  - The prescaler counts 0..`CLK_HZ/TICK_HZ-1` and then wraps. On the wrap, the 32-bit timer increments, wrapping 0xFFFF_FFFF→0.
  - A timer write clears both the timer and the prescaler. A write on the same edge as a tick wins, leaving the timer at 0.
- **Reset while `rst` is low:**
  - Cleared to 0: `dReadData`, `led`, timer, prescaler, status, synchronizer flops.
  - RAM contents are not reset.
  - Any access in flight at reset is discarded.

## Timing
- Write: takes effect at the rising edge where `MemWrite` is sampled high.
- Read: `dReadData` is valid one cycle after the edge sampling `MemRead`. There are no wait states and no handshake beyond the strobes.
- Read-after-write: a read of the same address on the next cycle returns the new data (RAM write-first). An LED write followed by an LED read the next cycle returns the new value.
- Switch/button latency: 2 cycles from an input change to register visibility. A read then adds 1 more cycle.
- Timer: first increment occurs `CLK_HZ/TICK_HZ` cycles after reset release or after a timer write.

## Structure
- Package `riscv_io_pkg`:
  - offset constants `IO_LED`, `IO_SW`, `IO_BTN`, `IO_TIMER`, `IO_STATUS`
  - status bit indices `ST_MISALIGN`, `ST_COLLIDE`
  - default base-address constants
- Sub-module `riscv_data_ram`: single-port synchronous RAM, `MEM_WORDS`×32, write-first, registered output, inferred as BRAM.
- Top level contains the decoder, I/O registers, synchronizers, timer and read-data mux/register.

## Test plan
- **RAM write/read:** write 0xDEADBEEF to 0x2004, read 0x2004 next cycle → `dReadData`=0xDEADBEEF one cycle later; read 0x2000 → initial contents, no status change.
- **LED:** write 0x1234_ABCD to 0x7F00 → `led`=0xABCD on that edge; readback → 0x0000_ABCD. Switch test: `sw`=0x00F0 → a read issued ≥2 cycles later returns 0x0000_00F0.
- **Timer:** with `CLK_HZ`=10, `TICK_HZ`=1, reset → timer reads 3 after 30 cycles. Write 0x7F0C on a tick edge → next read returns 0.
- **Errors:**
  - Read 0x2002 → `dReadData` unchanged, status reads 0x1.
  - Assert MemRead & MemWrite together → write performed, status reads 0x3.
  - Write 0x3 to 0x7F10 → status reads 0.
- **Boundaries:** read 0x2000+4*`MEM_WORDS` and 0x7F20 → 0. Write to 0x7F04 → switch value unaffected.
- **Reset mid-operation:** drive `rst` low asynchronously between clock edges while LED=0xFFFF and timer≠0 → `led`, `dReadData`, timer and status all 0 immediately. After release, RAM data written before reset is still readable.

Source files
------------

// File: rtl/riscv_io_pkg.sv
// Shared constants for the RISC-V data-side bus: default base addresses,
// I/O register offsets, status bit positions and the read-source select type.
// Latency: n/a (declarations only). Backpressure: n/a.
package riscv_io_pkg;

    localparam logic [31:0] DEF_DATA_BASE = 32'h0000_2000;
    localparam logic [31:0] DEF_IO_BASE   = 32'h0000_7F00;
    localparam logic [32:0] IO_SPAN       = 33'h0_0000_0020;

    // Byte offsets inside the I/O block
    localparam logic [4:0] IO_LED    = 5'h00;
    localparam logic [4:0] IO_SW     = 5'h04;
    localparam logic [4:0] IO_BTN    = 5'h08;
    localparam logic [4:0] IO_TIMER  = 5'h0C;
    localparam logic [4:0] IO_STATUS = 5'h10;

    // Sticky status bits
    localparam int ST_MISALIGN = 0;
    localparam int ST_COLLIDE  = 1;

    // Which registered source currently drives the read-data port
    typedef enum logic {
        RSEL_IO  = 1'b0,
        RSEL_RAM = 1'b1
    } rsel_e;

    // base <= addr < base + span, evaluated in 33 bits so the top of the
    // window cannot wrap past 2^32.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
        logic [32:0] a;
        logic [32:0] b;
        a = {1'b0, addr};
        b = {1'b0, base};
        return (a >= b) && (a < (b + span));
    endfunction

endpackage

// File: rtl/riscv_data_ram.sv
// Single-port synchronous data RAM, MEM_WORDS x 32, write-first, registered output.
// Latency: write lands on the sampling edge; read data valid after the edge with re_i high.
// Backpressure: none; output register holds whenever re_i is low.
//   clk_i   : clock
//   we_i    : write strobe, re_i : read strobe (updates rdata_o)
//   addr_i  : word index, wdata_i : store data, rdata_o : registered read data
module riscv_data_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    // No reset on the array or output register so the tools can map both
    // onto block RAM primitives.
    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        // Output only moves on a read, so a later write cannot disturb data
        // the processor has not consumed yet. Write-first on a same-edge hit.
        if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_data_bus.sv
// Data-side memory/I-O subsystem behind a multicycle RISC-V core: RAM plus LED,
// switch, button, millisecond timer and sticky status registers.
// Latency: writes on the sampling edge, read data valid one cycle later; no backpressure.
//   clk, rst (async active-low)
//   dAddress/dWriteData/MemRead/MemWrite : processor strobes, dReadData : read data
//   sw/btn : asynchronous board inputs, led : LED register
module riscv_data_bus
    import riscv_io_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [31:0] IO_BASE   = DEF_IO_BASE,
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TICK_HZ   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dReadData,
    input  logic [15:0] sw,
    input  logic [3:0]  btn,
    output logic [15:0] led
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam int          DIV      = CLK_HZ / TICK_HZ;
    localparam int          PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [32:0] RAM_SPAN = 33'(MEM_WORDS) << 2;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          aligned;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_hit;
    logic          io_hit;
    logic [31:0]   ram_off;
    logic [31:0]   io_off;
    logic [AW-1:0] ram_idx;
    logic [4:0]    io_reg;

    assign aligned = (dAddress[1:0] == 2'b00);
    // A collision keeps the write and drops the read.
    assign wr_ok   = MemWrite & aligned;
    assign rd_ok   = MemRead & ~MemWrite & aligned;
    assign ram_hit = in_window(dAddress, DATA_BASE, RAM_SPAN);
    assign io_hit  = in_window(dAddress, IO_BASE, IO_SPAN);
    assign ram_off = dAddress - DATA_BASE;
    assign io_off  = dAddress - IO_BASE;
    assign ram_idx = ram_off[AW+1:2];
    assign io_reg  = io_off[4:0];

    // Bits outside the window offsets are don't-care once the hit is known.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_off[31:AW+2], ram_off[1:0], io_off[31:5]};

    logic io_wr;
    assign io_wr = wr_ok & io_hit;

    // ------------------------------------------------------------------
    // Data RAM. Strobes are gated by reset so nothing in flight lands
    // while the block is held in reset.
    // ------------------------------------------------------------------
    logic [31:0] ram_rdata;

    riscv_data_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_ok & ram_hit & rst),
        .re_i    (rd_ok & ram_hit & rst),
        .addr_i  (ram_idx),
        .wdata_i (dWriteData),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   sw_s1_q, sw_s2_q;
    logic [3:0]    btn_s1_q, btn_s2_q;
    logic [15:0]   led_q, led_d;
    logic [31:0]   timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    status_q, status_d;
    logic [31:0]   io_rdata_q, io_rdata_d;
    rsel_e         rsel_q, rsel_d;

    logic          tick;
    logic [1:0]    st_set;
    logic [1:0]    st_clr;
    logic [31:0]   io_mux;

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        led_d      = led_q;
        timer_d    = timer_q;
        presc_d    = presc_q;
        st_set     = 2'b00;
        st_clr     = 2'b00;
        status_d   = status_q;
        io_mux     = 32'h0;
        io_rdata_d = io_rdata_q;
        rsel_d     = rsel_q;

        if (io_wr && io_reg == IO_LED) begin
            led_d = dWriteData[15:0];
        end

        // A timer write outranks a tick on the same edge.
        if (io_wr && io_reg == IO_TIMER) begin
            timer_d = 32'h0;
            presc_d = '0;
        end else if (tick) begin
            timer_d = timer_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        st_set[ST_MISALIGN] = (MemRead | MemWrite) & ~aligned;
        st_set[ST_COLLIDE]  = MemRead & MemWrite & aligned;
        if (io_wr && io_reg == IO_STATUS) begin
            st_clr = dWriteData[1:0];
        end
        // Clear first, then set, so a same-edge set survives.
        status_d = (status_q & ~st_clr) | st_set;

        case (io_reg)
            IO_LED:    io_mux = {16'h0, led_q};
            IO_SW:     io_mux = {16'h0, sw_s2_q};
            IO_BTN:    io_mux = {28'h0, btn_s2_q};
            IO_TIMER:  io_mux = timer_q;
            IO_STATUS: io_mux = {30'h0, status_q};
            default:   io_mux = 32'h0;
        endcase

        // RAM reads are captured in the RAM's own output register; I/O and
        // unmapped reads are captured here. The select remembers which one
        // the last valid read targeted.
        if (rd_ok) begin
            rsel_d = ram_hit ? RSEL_RAM : RSEL_IO;
            if (!ram_hit) begin
                io_rdata_d = io_hit ? io_mux : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            led_q      <= '0;
            timer_q    <= '0;
            presc_q    <= '0;
            status_q   <= '0;
            io_rdata_q <= '0;
            rsel_q     <= RSEL_IO;
        end else begin
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            led_q      <= led_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            status_q   <= status_d;
            io_rdata_q <= io_rdata_d;
            rsel_q     <= rsel_d;
        end
    end

    // Both sources are registers; reset forces the I/O side (zero).
    assign dReadData = (rsel_q == RSEL_RAM) ? ram_rdata : io_rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_riscv_data_bus.sv
module tb_riscv_data_bus;

    logic        clk;
    logic        rst;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dReadData;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;

    int errors = 0;
    int checks = 0;

    riscv_data_bus #(
        .MEM_WORDS (1024),
        .DATA_BASE (32'h0000_2000),
        .IO_BASE   (32'h0000_7F00),
        .CLK_HZ    (10),
        .TICK_HZ   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dReadData  (dReadData),
        .sw         (sw),
        .btn        (btn),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        dAddress   = addr;
        dWriteData = data;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        access(1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        access(1'b0, 1'b1, addr, data);
    endtask

    initial begin
        rst        = 1'b0;
        dAddress   = 32'h0;
        dWriteData = 32'h0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        sw         = 16'h0;
        btn        = 4'h0;

        // Reset state
        #12;
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_rdata", dReadData, 32'h0);

        // Timer: divider of 10, three ticks after 30 edges
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        rd(32'h7F0C);
        check("timer_30cyc", dReadData, 32'd3);
        repeat (8) @(posedge clk);
        wr(32'h7F0C, 32'hFFFF_FFFF);          // lands on the 4th tick edge
        rd(32'h7F0C);
        check("timer_clr_on_tick", dReadData, 32'd0);
        repeat (8) @(posedge clk);
        rd(32'h7F0C);                          // 10th edge after clear: still old value
        check("timer_pre_first_tick", dReadData, 32'd0);
        rd(32'h7F0C);
        check("timer_first_tick", dReadData, 32'd1);

        rd(32'h7F10);
        check("status_clean", dReadData, 32'h0);

        // RAM write / read, last word
        wr(32'h2004, 32'hDEAD_BEEF);
        rd(32'h2004);
        check("ram_raw", dReadData, 32'hDEAD_BEEF);
        rd(32'h2000);
        rd(32'h7F10);
        check("ram_word0_no_status", dReadData, 32'h0);
        wr(32'h2FFC, 32'hA5A5_5A5A);
        rd(32'h2FFC);
        check("ram_last_word", dReadData, 32'hA5A5_5A5A);

        // LED
        wr(32'h7F00, 32'h1234_ABCD);
        check("led_on_write_edge", {16'h0, led}, 32'h0000_ABCD);
        rd(32'h7F00);
        check("led_readback", dReadData, 32'h0000_ABCD);

        // Switch synchronizer latency
        sw = 16'h00F0;
        rd(32'h7F04);
        check("sw_lat1", dReadData, 32'h0);
        rd(32'h7F04);
        check("sw_lat2", dReadData, 32'h0);
        rd(32'h7F04);
        check("sw_visible", dReadData, 32'h0000_00F0);

        btn = 4'hA;
        repeat (2) @(posedge clk);
        rd(32'h7F08);
        check("btn_visible", dReadData, 32'h0000_000A);

        wr(32'h7F04, 32'hFFFF_FFFF);
        rd(32'h7F04);
        check("sw_write_ignored", dReadData, 32'h0000_00F0);

        // Boundaries / unmapped
        rd(32'h3000);
        check("ram_end_unmapped", dReadData, 32'h0);
        rd(32'h7F00);
        rd(32'h7F20);
        check("io_end_unmapped", dReadData, 32'h0);
        rd(32'h7F00);
        rd(32'h7F14);
        check("io_hole", dReadData, 32'h0);
        wr(32'h3000, 32'h1234);
        rd(32'h3000);
        check("unmapped_wr_ignored", dReadData, 32'h0);

        // Misaligned read
        rd(32'h2004);
        rd(32'h2002);
        check("misalign_hold", dReadData, 32'hDEAD_BEEF);
        rd(32'h7F10);
        check("status_misalign", dReadData, 32'h1);

        // Collision
        access(1'b1, 1'b1, 32'h2008, 32'h0000_0055);
        check("collide_hold", dReadData, 32'h1);
        rd(32'h2008);
        check("collide_write_done", dReadData, 32'h0000_0055);
        rd(32'h7F10);
        check("status_both", dReadData, 32'h3);

        // Collision on a W1C write of both bits: collide set wins, misalign clears
        access(1'b1, 1'b1, 32'h7F10, 32'h3);
        check("race_hold", dReadData, 32'h3);
        rd(32'h7F10);
        check("status_race", dReadData, 32'h2);
        wr(32'h7F10, 32'h3);
        rd(32'h7F10);
        check("status_w1c", dReadData, 32'h0);

        // Misaligned write is dropped
        wr(32'h2006, 32'h0000_0BAD);
        rd(32'h2004);
        check("misalign_wr_dropped", dReadData, 32'hDEAD_BEEF);
        wr(32'h7F10, 32'h1);

        // Reset mid-operation
        wr(32'h7F00, 32'h0000_FFFF);
        check("led_ffff", {16'h0, led}, 32'h0000_FFFF);
        rd(32'h7F0C);
        check("timer_running", {31'h0, (dReadData != 32'h0)}, 32'h1);
        rd(32'h2004);
        rd(32'h2001);                          // sets misalign, holds DEADBEEF
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_led", {16'h0, led}, 32'h0);
        check("async_rst_rdata", dReadData, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd(32'h7F0C);
        check("rst_timer", dReadData, 32'h0);
        rd(32'h7F10);
        check("rst_status", dReadData, 32'h0);
        rd(32'h7F00);
        check("rst_led_reg", dReadData, 32'h0);
        rd(32'h2004);
        check("ram_kept_2004", dReadData, 32'hDEAD_BEEF);
        rd(32'h2FFC);
        check("ram_kept_2ffc", dReadData, 32'hA5A5_5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
